data_bank: RTL

DATA_BANK -- requirements
Module: data_bank

---
 rtl/data_bank_pkg.sv | 19 +
 rtl/data_bank_imm_gen.sv | 53 +++++
 rtl/data_bank.sv | 100 ++++++++++
 3 files changed

// File: rtl/data_bank_pkg.sv
// data_bank_pkg: shared encodings for the immediate generator mode and write-back source select.
// Revision: 1.0
`default_nettype none

package data_bank_pkg;

  localparam logic [1:0] SEXT    = 2'd0;
  localparam logic [1:0] ZEXT    = 2'd1;
  localparam logic [1:0] LOAD_UI = 2'd2;
  localparam logic [1:0] CONCAT  = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MDR  = 2'd1;
  localparam logic [1:0] WB_IMM  = 2'd2;
  localparam logic [1:0] WB_NONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/data_bank_imm_gen.sv
// imm_gen: registered immediate generator with an upper-immediate holding register.
// Revision: 1.0
`default_nettype none

module imm_gen
  import data_bank_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMM_F = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] imm,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] imm_value,
  output logic             ui_valid
);

  localparam int UIW = WIDTH - IMM_F;

  logic [UIW-1:0]   ui_reg;
  logic [IMM_F-1:0] low_field;
  logic             unused_imm;

  assign low_field  = imm[IMM_F-1:0];
  // Which raw immediate bits matter depends on the mode; reference the whole word once.
  assign unused_imm = ^imm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_value <= '0;
      ui_reg    <= '0;
      ui_valid  <= 1'b0;
    end else begin
      case (mode)
        SEXT:    imm_value <= {{UIW{low_field[IMM_F-1]}}, low_field};
        ZEXT:    imm_value <= {{UIW{1'b0}}, low_field};
        LOAD_UI: begin
          ui_reg   <= imm[UIW-1:0];
          ui_valid <= 1'b1;
        end
        CONCAT:  begin
          imm_value <= {ui_reg, low_field};
          ui_valid  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_bank.sv
// data_bank: register file with write-back mux, same-cycle bypass and registered A/B operands.
// Revision: 1.0
`default_nettype none

module data_bank
  import data_bank_pkg::*;
#(
  parameter int  WIDTH   = 16,
  parameter int  NREGS   = 8,
  parameter int  IMM_F   = 7,
  parameter int  ZERO_R0 = 0,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [AW-1:0]    input_reg_readA_address,
  input  logic [AW-1:0]    input_reg_readB_address,
  input  logic             input_reg_write,
  input  logic [AW-1:0]    input_reg_write_address,
  input  logic [1:0]       input_wb_sel,
  input  logic             input_branch,
  input  logic [WIDTH-1:0] input_ALUOut,
  input  logic [WIDTH-1:0] input_MDR,
  input  logic [WIDTH-1:0] input_imm,
  input  logic [1:0]       input_imm_mode,
  input  logic             input_AB_load,
  output logic [WIDTH-1:0] output_reg_A,
  output logic [WIDTH-1:0] output_reg_B,
  output logic [WIDTH-1:0] output_imm,
  output logic             output_ui_valid
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [AW-1:0]    addr_b;
  logic             write_en;
  logic [WIDTH-1:0] wb_data;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;

  // An address is backed by storage unless it is past the array or is a hardwired-zero r0.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < 32'(NREGS)) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  assign addr_b   = input_branch ? input_reg_write_address : input_reg_readB_address;
  assign write_en = input_reg_write && (input_wb_sel != WB_NONE) && addr_ok(input_reg_write_address);

  always_comb begin
    wb_data = '0;
    case (input_wb_sel)
      WB_ALU:  wb_data = input_ALUOut;
      WB_MDR:  wb_data = input_MDR;
      WB_IMM:  wb_data = output_imm;
      default: wb_data = '0;
    endcase
  end

  // A write landing this edge on an operand's address supersedes the stored value.
  always_comb begin
    next_a = '0;
    next_b = '0;
    if (write_en && (input_reg_write_address == input_reg_readA_address))
      next_a = wb_data;
    else if (addr_ok(input_reg_readA_address))
      next_a = regs[input_reg_readA_address];
    if (write_en && (input_reg_write_address == addr_b))
      next_b = wb_data;
    else if (addr_ok(addr_b))
      next_b = regs[addr_b];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      output_reg_A <= '0;
      output_reg_B <= '0;
    end else begin
      if (write_en) regs[input_reg_write_address] <= wb_data;
      if (input_AB_load) begin
        output_reg_A <= next_a;
        output_reg_B <= next_b;
      end
    end
  end

  imm_gen #(
    .WIDTH (WIDTH),
    .IMM_F (IMM_F)
  ) u_imm_gen (
    .clk       (CLK),
    .rst       (RST),
    .imm       (input_imm),
    .mode      (input_imm_mode),
    .imm_value (output_imm),
    .ui_valid  (output_ui_valid)
  );

endmodule

`default_nettype wire
